// File: rtl/avr_addr_loader.sv
// avr_addr_loader: serial SRAM address front-end for the AVR control pins.
// The AVR shifts an address in MSB-first while the previous address shifts out
// on avr_so for readback. A frame of exactly ADDR_W bits is committed to
// sram_addr. Any other frame length is rejected with a frame_err pulse.
// sram_addr auto-increments on every inc_strobe from the SRAM bridge.
module avr_addr_loader #(
    parameter int unsigned         ADDR_W   = 21,
    parameter logic [ADDR_W-1:0]   RST_ADDR = '0
) (
    input  logic              avr_clk,
    input  logic              reset,
    input  logic              avr_shift,
    input  logic              avr_si,
    output logic              avr_so,
    input  logic              inc_strobe,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              addr_valid,
    output logic              commit,
    output logic              frame_err,
    output logic              busy
);

    // The counter must reach ADDR_W+1, which is the saturating "overlong" marker.
    localparam int unsigned CNT_W = $clog2(ADDR_W + 2);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(ADDR_W);
    localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(ADDR_W + 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   buf_q, buf_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                valid_q, valid_d;
    logic                commit_q, commit_d;
    logic                err_q, err_d;
    logic [ADDR_W-1:0]   addr_inc;

    // Incremented address; the natural wrap from all ones to zero is intended.
    assign addr_inc = addr_q + ADDR_ONE;

    // State, shift buffer, address and pulse registers.
    always_ff @(posedge avr_clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            buf_q    <= '0;
            addr_q   <= RST_ADDR;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            commit_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            buf_q    <= buf_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            commit_q <= commit_d;
            err_q    <= err_d;
        end
    end

    // Next-state logic: frame capture, end-of-frame check and auto-increment.
    always_comb begin
        state_d  = state_q;
        buf_d    = buf_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        valid_d  = valid_q;
        commit_d = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (inc_strobe) begin
                    addr_d = addr_inc;
                end
                if (avr_shift) begin
                    // Preload from the current address so its MSB has already been
                    // presented on avr_so, then take the first data bit on this edge.
                    buf_d   = {addr_q[ADDR_W-2:0], avr_si};
                    cnt_d   = CNT_ONE;
                    state_d = SHIFT;
                end else begin
                    // Keep the buffer mirroring the address so readback is ready.
                    buf_d = addr_d;
                end
            end

            SHIFT: begin
                if (avr_shift) begin
                    buf_d = {buf_q[ADDR_W-2:0], avr_si};
                    if (cnt_q != CNT_SAT) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                    if (inc_strobe) begin
                        addr_d = addr_inc;
                    end
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    if (cnt_q == CNT_FULL) begin
                        // A commit overrides any increment on the same edge.
                        addr_d   = buf_q;
                        commit_d = 1'b1;
                        valid_d  = 1'b1;
                    end else begin
                        err_d = 1'b1;
                        if (inc_strobe) begin
                            addr_d = addr_inc;
                        end
                    end
                    buf_d = addr_d;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign avr_so     = buf_q[ADDR_W-1];
    assign sram_addr  = addr_q;
    assign addr_valid = valid_q;
    assign commit     = commit_q;
    assign frame_err  = err_q;
    assign busy       = (state_q == SHIFT);

endmodule

// File: tb/tb_avr_addr_loader.sv
// tb_avr_addr_loader: randomized and directed bench for avr_addr_loader with a
// frame-level reference model and hand-computed literal expectations.
module tb_avr_addr_loader;

    localparam int AW = 21;
    localparam logic [AW-1:0] RA = '0;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sh  = 1'b0;
    logic          si  = 1'b0;
    logic          inc = 1'b0;
    logic          so, valid, commit, err, busy;
    logic [AW-1:0] addr;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    avr_addr_loader #(.ADDR_W(AW), .RST_ADDR(RA)) dut (
        .avr_clk    (clk),
        .reset      (rst),
        .avr_shift  (sh),
        .avr_si     (si),
        .avr_so     (so),
        .inc_strobe (inc),
        .sram_addr  (addr),
        .addr_valid (valid),
        .commit     (commit),
        .frame_err  (err),
        .busy       (busy)
    );

    // Reference model: a frame is the list of bits seen while avr_shift is high.
    // The readback stream is the starting address MSB-first followed by the
    // frame bits; avr_so shows the element whose index is the bit count so far.
    logic [AW-1:0] m_addr = RA;
    logic [AW-1:0] m_fv   = '0;
    bit            m_valid, m_commit, m_err, m_in;
    int            m_k;
    bit            m_seq[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_addr   = RA;
            m_valid  = 1'b0;
            m_commit = 1'b0;
            m_err    = 1'b0;
            m_in     = 1'b0;
            m_k      = 0;
            m_fv     = '0;
            m_seq.delete();
        end else begin
            m_commit = 1'b0;
            m_err    = 1'b0;
            if (!m_in) begin
                if (sh) begin
                    m_seq.delete();
                    for (int i = AW - 1; i >= 0; i--) m_seq.push_back(m_addr[i]);
                    m_seq.push_back(si);
                    m_fv = AW'(si);
                    m_k  = 1;
                    m_in = 1'b1;
                end
                if (inc) m_addr = m_addr + 1;
            end else if (sh) begin
                m_seq.push_back(si);
                m_fv = {m_fv[AW-2:0], si};
                m_k  = m_k + 1;
                if (inc) m_addr = m_addr + 1;
            end else begin
                m_in = 1'b0;
                if (m_k == AW) begin
                    m_addr   = m_fv;
                    m_commit = 1'b1;
                    m_valid  = 1'b1;
                end else begin
                    m_err = 1'b1;
                    if (inc) m_addr = m_addr + 1;
                end
                m_k = 0;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            bit e_so;
            e_so = m_in ? m_seq[m_k] : m_addr[AW-1];
            n_tests++;
            if (addr !== m_addr || valid !== m_valid || commit !== m_commit ||
                err !== m_err || busy !== m_in || so !== e_so) begin
                n_fail++;
                $display("FAIL model t=%0t addr=%h(want %h) valid=%b(want %b) commit=%b(want %b) err=%b(want %b) busy=%b(want %b) so=%b(want %b)",
                         $time, addr, m_addr, valid, m_valid, commit, m_commit,
                         err, m_err, busy, m_in, so, e_so);
            end
        end
    end

    task automatic check(input string name, input logic [AW-1:0] got, input logic [AW-1:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic drive(input logic s, input logic d, input logic i);
        @(negedge clk);
        sh  = s;
        si  = d;
        inc = i;
    endtask

    task automatic shift_word(input logic [63:0] value, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) drive(1'b1, value[i], 1'b0);
    endtask

    // Full frame followed by the end edge and one settle cycle.
    task automatic load(input logic [AW-1:0] value);
        shift_word(64'(value), AW);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        sh  = 1'b0;
        si  = 1'b0;
        inc = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [AW-1:0] rb;
        logic [AW-1:0] steps [3];

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_addr", addr, RA);
        check("rst_valid", AW'(valid), '0);
        check("rst_busy", AW'(busy), '0);
        check("rst_so", AW'(so), '0);
        check("rst_pulses", AW'({commit, err}), '0);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;

        // 1: clean 21-bit frame commits one cycle after the last bit
        shift_word(64'h0ABCDE, AW);
        drive(1'b0, 1'b0, 1'b0);
        check("t1_busy_last", AW'(busy), AW'(1));
        drive(1'b0, 1'b0, 1'b0);
        check("t1_commit", AW'(commit), AW'(1));
        check("t1_addr", addr, 21'h0ABCDE);
        check("t1_valid", AW'(valid), AW'(1));
        drive(1'b0, 1'b0, 1'b0);
        check("t1_commit_drop", AW'(commit), '0);

        // 2: readback of the old address while loading a new one
        rb = '0;
        for (int i = AW - 1; i >= 0; i--) begin
            drive(1'b1, (i == 4) ? 1'b1 : 1'b0, 1'b0);
            rb[i] = so;
        end
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        check("t2_readback", rb, 21'h0ABCDE);
        check("t2_addr", addr, 21'h000010);

        // 3: auto-increment wraps from all ones to zero
        load(21'h1FFFFE);
        steps[0] = 21'h1FFFFF;
        steps[1] = 21'h000000;
        steps[2] = 21'h000001;
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, 1'b1);
            drive(1'b0, 1'b0, 1'b0);
            check("t3_inc", addr, steps[k]);
        end

        // 4: short and overlong frames are rejected
        shift_word(64'h2A5A, 14);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        check("t4_err_short", AW'(err), AW'(1));
        check("t4_commit_short", AW'(commit), '0);
        check("t4_addr_short", addr, 21'h000001);
        shift_word(64'h3FFFFF, 22);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        check("t4_err_long", AW'(err), AW'(1));
        check("t4_addr_long", addr, 21'h000001);

        // 5: commit beats a simultaneous increment; mid-frame increment applies
        load(21'h000005);
        shift_word(64'h000100, AW);
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        check("t5_commit_wins", addr, 21'h000100);
        load(21'h000005);
        for (int i = AW - 1; i >= 0; i--) begin
            logic [AW-1:0] v;
            v = 21'h000100;
            drive(1'b1, v[i], (i == 10) ? 1'b1 : 1'b0);
        end
        drive(1'b0, 1'b0, 1'b0);
        check("t5_mid_inc", addr, 21'h000006);
        drive(1'b0, 1'b0, 1'b0);
        check("t5_after_commit", addr, 21'h000100);

        // 6: asynchronous reset mid-frame, then a clean frame
        shift_word(64'h155, 10);
        #2;
        rst = 1'b1;
        sh  = 1'b0;
        #1;
        check("t6_addr", addr, RA);
        check("t6_flags", AW'({valid, busy, so, commit, err}), '0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        load(21'h012345);
        check("t6_reload", addr, 21'h012345);

        // Randomized frames of mixed length with increments and resets
        for (int f = 0; f < 80; f++) begin
            int len, sel, gap, abort_at;
            sel = $urandom_range(0, 3);
            if (sel <= 1)      len = AW;
            else if (sel == 2) len = $urandom_range(1, AW - 1);
            else               len = $urandom_range(AW + 1, AW + 6);
            abort_at = ($urandom_range(0, 11) == 0) ? $urandom_range(0, len - 1) : -1;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++)
                drive(1'b0, 1'b0, ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0);
            for (int b = 0; b < len; b++) begin
                if (b == abort_at) break;
                drive(1'b1, 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 5) == 0) ? 1'b1 : 1'b0);
            end
            if (abort_at >= 0) begin
                pulse_reset();
            end else begin
                drive(1'b0, 1'b0, ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0);
                drive(1'b0, 1'b0, 1'b0);
            end
        end
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
